// File: rtl/clkgen_multi.sv
// clkgen_multi: NUM_CLOCKS programmable refclk dividers with phase offset, lock flag and
// per-channel enable pulses. Define CLKGEN_CASCADE_EN to add the cascade_out enable tap.
module clkgen_multi #(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int LOCK_CYCLES = 256,
  parameter int RESET_DIV   = 5,
  localparam int CHAN_W     = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [DIV_WIDTH-1:0]  cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
`ifdef CLKGEN_CASCADE_EN
  ,
  output logic                  cascade_out
`endif
);

  localparam int SETTLE_W = $clog2(LOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_RECONF = 2'd2
  } state_t;

  state_t                r_state;
  logic [SETTLE_W-1:0]   r_settle;
  logic                  r_locked;
  logic                  r_ready;
  logic [NUM_CLOCKS-1:0] r_outclk;
  logic [NUM_CLOCKS-1:0] r_outclk_en;

  logic [DIV_WIDTH-1:0]  r_div   [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]  r_phase [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]  r_cnt   [NUM_CLOCKS];

  logic [DIV_WIDTH-1:0]  w_deff     [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]  w_peff     [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]  w_preset   [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0]  w_next_cnt [NUM_CLOCKS];
  logic [DIV_WIDTH:0]    w_half     [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] w_hi_next;
  logic [NUM_CLOCKS-1:0] w_hi_preset;
  logic [NUM_CLOCKS-1:0] w_en_next;
  logic [NUM_CLOCKS-1:0] w_en_preset;

  logic w_accept;
  logic w_enter_run;
  logic w_chan_ok;
  logic w_running;

  assign w_accept    = (r_state == ST_RUN) && r_ready && cfg_valid;
  assign w_enter_run = (r_state == ST_SETTLE) && (r_settle == SETTLE_W'(LOCK_CYCLES - 1));
  assign w_chan_ok   = (int'(cfg_chan) < NUM_CLOCKS);
  assign w_running   = (r_state == ST_RUN) && !w_accept;

  // Per-channel effective ratio/phase and the next counter value with its output levels.
  // A phase at or beyond the ratio clamps to D-1; counters preset to (D-P) mod D.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      w_deff[i]      = (r_div[i] == '0) ? DIV_WIDTH'(1) : r_div[i];
      w_peff[i]      = (r_phase[i] >= w_deff[i]) ? (w_deff[i] - DIV_WIDTH'(1)) : r_phase[i];
      w_preset[i]    = (w_peff[i] == '0) ? '0 : (w_deff[i] - w_peff[i]);
      w_next_cnt[i]  = (r_cnt[i] >= (w_deff[i] - DIV_WIDTH'(1))) ? '0 : (r_cnt[i] + DIV_WIDTH'(1));
      w_half[i]      = ({1'b0, w_deff[i]} + (DIV_WIDTH + 1)'(1)) >> 1'b1;
      w_hi_next[i]   = ({1'b0, w_next_cnt[i]} < w_half[i]);
      w_hi_preset[i] = ({1'b0, w_preset[i]} < w_half[i]);
      w_en_next[i]   = (w_next_cnt[i] == '0);
      w_en_preset[i] = (w_preset[i] == '0);
    end
  end

  // Control FSM: settle count, lock flag and request acceptance.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_SETTLE;
      r_settle <= '0;
      r_locked <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (w_enter_run) begin
            r_state  <= ST_RUN;
            r_settle <= '0;
            r_locked <= 1'b1;
            r_ready  <= 1'b1;
          end else begin
            r_settle <= r_settle + SETTLE_W'(1);
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_state  <= ST_RECONF;
            r_locked <= 1'b0;
            r_ready  <= 1'b0;
          end
        end
        ST_RECONF: begin
          r_state  <= ST_SETTLE;
          r_settle <= '0;
          r_locked <= 1'b0;
          r_ready  <= 1'b0;
        end
        default: begin
          r_state  <= ST_SETTLE;
          r_settle <= '0;
          r_locked <= 1'b0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  // Channel shadows, phase counters and registered clock/enable outputs.
  // Out-of-range channel numbers complete the handshake without touching any shadow.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        r_div[i]   <= DIV_WIDTH'(RESET_DIV);
        r_phase[i] <= '0;
        r_cnt[i]   <= '0;
      end
      r_outclk    <= '0;
      r_outclk_en <= '0;
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (w_accept && w_chan_ok && (cfg_chan == CHAN_W'(i))) begin
          r_div[i]   <= cfg_div;
          r_phase[i] <= cfg_phase;
        end
        if (w_enter_run) begin
          r_cnt[i]       <= w_preset[i];
          r_outclk[i]    <= w_hi_preset[i];
          r_outclk_en[i] <= w_en_preset[i];
        end else if (w_running) begin
          r_cnt[i]       <= w_next_cnt[i];
          r_outclk[i]    <= w_hi_next[i];
          r_outclk_en[i] <= w_en_next[i];
        end else begin
          r_cnt[i]       <= '0;
          r_outclk[i]    <= 1'b0;
          r_outclk_en[i] <= 1'b0;
        end
      end
    end
  end

  assign outclk    = r_outclk;
  assign outclk_en = r_outclk_en;
  assign locked    = r_locked;
  assign cfg_ready = r_ready;

`ifdef CLKGEN_CASCADE_EN
  logic r_cascade;

  // Last channel's enable delayed one cycle; forced low whenever lock is being dropped or absent.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_cascade <= 1'b0;
    end else if (w_running) begin
      r_cascade <= r_outclk_en[NUM_CLOCKS-1] & r_locked;
    end else begin
      r_cascade <= 1'b0;
    end
  end

  assign cascade_out = r_cascade;
`endif

endmodule

// File: tb/tb_clkgen_multi.sv
// Self-checking bench for clkgen_multi: randomized reconfiguration checked against a
// time-since-lock model of each channel's waveform.
module tb_clkgen_multi;

  localparam int NC = 5;
  localparam int DW = 16;
  localparam int LC = 256;
  localparam int RD = 5;
  localparam int CW = 3;
  localparam int W  = 40;

  logic          refclk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan = '0;
  logic [DW-1:0] cfg_div = '0;
  logic [DW-1:0] cfg_phase = '0;
  logic [NC-1:0] outclk;
  logic [NC-1:0] outclk_en;
  logic          locked;
`ifdef CLKGEN_CASCADE_EN
  logic          cascade_out;
`endif

  int vectors = 0;
  int errors = 0;
  int m_div [NC];
  int m_ph  [NC];

  clkgen_multi #(
    .NUM_CLOCKS(NC), .DIV_WIDTH(DW), .LOCK_CYCLES(LC), .RESET_DIV(RD)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
`ifdef CLKGEN_CASCADE_EN
    , .cascade_out(cascade_out)
`endif
  );

  always #5 refclk = ~refclk;

  function automatic int eff_div(input int i);
    return (m_div[i] == 0) ? 1 : m_div[i];
  endfunction

  function automatic int eff_ph(input int i);
    int d;
    d = eff_div(i);
    return (m_ph[i] >= d) ? d - 1 : m_ph[i];
  endfunction

  // Position within the period, t cycles after lock, for channel i.
  function automatic int pos(input int i, input int t);
    int d;
    d = eff_div(i);
    return (((t - eff_ph(i)) % d) + d) % d;
  endfunction

  function automatic logic [NC-1:0] exp_clk(input int t);
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = (pos(i, t) < (eff_div(i) + 1) / 2);
    return r;
  endfunction

  function automatic logic [NC-1:0] exp_en(input int t);
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = (pos(i, t) == 0);
    return r;
  endfunction

  function automatic logic exp_casc(input int t);
    logic [NC-1:0] e;
    if (t == 0) return 1'b0;
    e = exp_en(t - 1);
    return e[NC-1];
  endfunction

  // Caller raises rst; holds it, releases, checks the lock latency and default waveforms.
  task automatic test_reset();
    cfg_valid = 1'b0;
    for (int i = 0; i < NC; i++) begin
      m_div[i] = RD;
      m_ph[i]  = 0;
    end
    repeat (3) begin
      @(negedge refclk);
      vectors++;
      if ({outclk, outclk_en, locked, cfg_ready} !== '0) begin
        errors++;
        $display("FAIL reset_hold: outclk=%b en=%b locked=%b ready=%b, required all zero",
                 outclk, outclk_en, locked, cfg_ready);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= LC; k++) begin
      @(negedge refclk);
      vectors++;
      if (locked !== (k == LC) || cfg_ready !== (k == LC)) begin
        errors++;
        $display("FAIL reset_lock k=%0d: locked=%b ready=%b, required %b", k, locked, cfg_ready, (k == LC));
      end
      if (k < LC && {outclk, outclk_en} !== '0) begin
        errors++;
        $display("FAIL reset_settle_out k=%0d: outclk=%b en=%b, required 0", k, outclk, outclk_en);
      end
    end
    for (int t = 0; t < W; t++) begin
      if (t > 0) @(negedge refclk);
      vectors++;
      if (outclk !== exp_clk(t) || outclk_en !== exp_en(t)) begin
        errors++;
        $display("FAIL reset_run t=%0d: outclk=%b en=%b, required outclk=%b en=%b",
                 t, outclk, outclk_en, exp_clk(t), exp_en(t));
      end
`ifdef CLKGEN_CASCADE_EN
      if (cascade_out !== exp_casc(t)) begin
        errors++;
        $display("FAIL reset_cascade t=%0d: cascade_out=%b, required %b", t, cascade_out, exp_casc(t));
      end
`endif
    end
  endtask

  // One handshake, the relock sequence with ignored junk requests, then the new waveforms.
  task automatic test_reconfig(input int chan, input int div, input int phase);
    @(negedge refclk);
    vectors++;
    if (cfg_ready !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL cfg_ready_run: ready=%b locked=%b, required 1 1", cfg_ready, locked);
    end
    cfg_valid = 1'b1;
    cfg_chan  = CW'(chan);
    cfg_div   = DW'(div);
    cfg_phase = DW'(phase);
    @(negedge refclk);
    vectors++;
    if ({outclk, outclk_en, locked, cfg_ready} !== '0) begin
      errors++;
      $display("FAIL cfg_accept: outclk=%b en=%b locked=%b ready=%b, required all zero",
               outclk, outclk_en, locked, cfg_ready);
    end
    if (chan < NC) begin
      m_div[chan] = div;
      m_ph[chan]  = phase;
    end
    for (int k = 1; k <= LC + 1; k++) begin
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_chan  = CW'($urandom);
      cfg_div   = DW'($urandom);
      cfg_phase = DW'($urandom);
      @(negedge refclk);
      vectors++;
      if (locked !== (k == LC + 1) || cfg_ready !== (k == LC + 1)) begin
        errors++;
        $display("FAIL cfg_relock k=%0d: locked=%b ready=%b, required %b", k, locked, cfg_ready, (k == LC + 1));
      end
      if (k <= LC && {outclk, outclk_en} !== '0) begin
        errors++;
        $display("FAIL cfg_settle_out k=%0d: outclk=%b en=%b, required 0", k, outclk, outclk_en);
      end
`ifdef CLKGEN_CASCADE_EN
      if (cascade_out !== 1'b0) begin
        errors++;
        $display("FAIL cfg_cascade_unlocked k=%0d: cascade_out=%b, required 0", k, cascade_out);
      end
`endif
    end
    cfg_valid = 1'b0;
    for (int t = 0; t < W; t++) begin
      if (t > 0) @(negedge refclk);
      vectors++;
      if (outclk !== exp_clk(t) || outclk_en !== exp_en(t) || locked !== 1'b1) begin
        errors++;
        $display("FAIL cfg_run ch=%0d D=%0d P=%0d t=%0d: outclk=%b en=%b locked=%b, required outclk=%b en=%b locked=1",
                 chan, div, phase, t, outclk, outclk_en, locked, exp_clk(t), exp_en(t));
      end
`ifdef CLKGEN_CASCADE_EN
      if (cascade_out !== exp_casc(t)) begin
        errors++;
        $display("FAIL cfg_cascade t=%0d: cascade_out=%b, required %b", t, cascade_out, exp_casc(t));
      end
`endif
    end
  endtask

  task automatic test_div_phase();
    test_reconfig(1, 4, 1);
  endtask

  task automatic test_div_one();
    test_reconfig(0, 1, 0);
    test_reconfig(2, 0, 3);
  endtask

  task automatic test_phase_clamp();
    test_reconfig(3, 3, 7);
  endtask

  task automatic test_bad_chan();
    test_reconfig(5, 9, 2);
    test_reconfig(7, 2, 1);
  endtask

  task automatic test_random_cfg();
    repeat (8) test_reconfig(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
  endtask

  // Asynchronous reset while outputs are high must clear them before the next edge.
  task automatic test_async_reset_run();
    int n;
    n = 0;
    @(negedge refclk);
    while (outclk === '0 && n < 20) begin
      @(negedge refclk);
      n++;
    end
    vectors++;
    if (outclk === '0) begin
      errors++;
      $display("FAIL async_run_wait: outclk=%b stayed zero for %0d cycles, required a high level", outclk, n);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({outclk, outclk_en, locked, cfg_ready} !== '0) begin
      errors++;
      $display("FAIL async_clear: outclk=%b en=%b locked=%b ready=%b, required all zero",
               outclk, outclk_en, locked, cfg_ready);
    end
    test_reset();
  endtask

  // Request held high through settling is never accepted; reset mid-settle restores D=5.
  task automatic test_reset_mid_settle();
    @(negedge refclk);
    cfg_valid = 1'b1;
    cfg_chan  = CW'(1);
    cfg_div   = DW'(7);
    cfg_phase = DW'(3);
    for (int k = 0; k < 100; k++) begin
      @(negedge refclk);
      cfg_div = DW'($urandom_range(1, 12));
      vectors++;
      if (cfg_ready !== 1'b0 || locked !== 1'b0) begin
        errors++;
        $display("FAIL settle_hold k=%0d: ready=%b locked=%b, required 0 0", k, cfg_ready, locked);
      end
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({outclk, outclk_en, locked, cfg_ready} !== '0) begin
      errors++;
      $display("FAIL settle_reset: outclk=%b en=%b locked=%b ready=%b, required all zero",
               outclk, outclk_en, locked, cfg_ready);
    end
    test_reset();
  endtask

  initial begin
    #2 rst = 1'b1;
    test_reset();
    test_div_phase();
    test_div_one();
    test_phase_clamp();
    test_bad_chan();
    test_random_cfg();
    test_async_reset_run();
    test_reset_mid_settle();
    test_reconfig(4, 6, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
